// File: rtl/ex_muldiv_sequencer_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ex_muldiv_sequencer_pkg;

  localparam int MD_XLEN  = 32;
  localparam int MD_CNT_W = 5;

  // funct3 encodings of the M-extension ops
  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } md_state_t;

  // rs1 is interpreted as signed for these ops (MUL low half is sign-agnostic)
  function automatic logic a_is_signed(input logic [2:0] f3);
    return (f3 == MD_MULH) || (f3 == MD_MULHSU) || (f3 == MD_DIV) || (f3 == MD_REM);
  endfunction

  // rs2 is interpreted as signed for these ops (MULHSU keeps rs2 unsigned)
  function automatic logic b_is_signed(input logic [2:0] f3);
    return (f3 == MD_MULH) || (f3 == MD_DIV) || (f3 == MD_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_sequencer_datapath.sv
// Iterative magnitude datapath: shift-add multiply / restoring divide, one bit per step.
// Latency: XLEN step strobes, result combinational from the registers while fix is high.
// Backpressure: none; purely strobe driven by the sequencer FSM.
module md_iter_datapath #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            fix,
  input  logic            is_div,
  input  logic            sel_hi,
  input  logic            neg_q,
  input  logic            neg_r,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] result
);

  // acc: product high half / partial remainder; lo: product low half / dividend->quotient
  logic [XLEN-1:0]   acc;
  logic [XLEN-1:0]   lo;
  logic [XLEN-1:0]   dvs;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;

  // One iteration of each algorithm, computed from the current registers
  always_comb begin
    mul_sum   = {1'b0, acc} + (lo[0] ? {1'b0, dvs} : '0);
    div_shift = {acc, lo[XLEN-1]};
    div_trial = div_shift - {1'b0, dvs};
  end

  // Operand load and per-cycle iteration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      lo  <= '0;
      dvs <= '0;
    end else if (load) begin
      acc <= '0;
      lo  <= op_a;
      dvs <= op_b;
    end else if (step) begin
      if (is_div) begin
        // restore (keep shifted value) when the trial subtract borrows
        if (div_trial[XLEN]) begin
          acc <= div_shift[XLEN-1:0];
          lo  <= {lo[XLEN-2:0], 1'b0};
        end else begin
          acc <= div_trial[XLEN-1:0];
          lo  <= {lo[XLEN-2:0], 1'b1};
        end
      end else begin
        acc <= mul_sum[XLEN:1];
        lo  <= {mul_sum[0], lo[XLEN-1:1]};
      end
    end
  end

  // Sign correction and result selection; output is forced low outside the fix cycle
  always_comb begin
    prod     = {acc, lo};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -lo   : lo;
    rem_fix  = neg_r ? -acc  : acc;
    result   = '0;
    if (fix) begin
      if (is_div) result = sel_hi ? rem_fix : quo_fix;
      else        result = sel_hi ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
    end
  end

endmodule

// File: rtl/ex_muldiv_sequencer.sv
// RV32M MUL/DIV/REM controller for the EX stage; stalls the front end while iterating.
// Latency: XLEN+2 cycles from accepted start to o_done; 1 cycle for div-by-zero / overflow.
// Backpressure: o_stall holds PC/IF/ID/ID-EX while busy; drops in DONE so EX/MEM captures o_result.
module ex_muldiv_sequencer
  import ex_muldiv_sequencer_pkg::*;
#(
  parameter int XLEN  = MD_XLEN,
  parameter int CNT_W = MD_CNT_W
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  input  logic            i_flush,
  output logic            o_stall,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]      f3_q;
  logic            neg_q_r;
  logic            neg_r_r;

  logic            accept;
  logic            sign_a;
  logic            sign_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            div_zero;
  logic            div_ovf;
  logic            special;
  logic [XLEN-1:0] special_res;
  logic            sel_hi;
  logic [XLEN-1:0] dp_result;

  // Operand decode at issue: signs, magnitudes and the two results known without iterating
  always_comb begin
    sign_a      = a_is_signed(i_funct3) & i_op_a[XLEN-1];
    sign_b      = b_is_signed(i_funct3) & i_op_b[XLEN-1];
    mag_a       = sign_a ? -i_op_a : i_op_a;
    mag_b       = sign_b ? -i_op_b : i_op_b;
    div_zero    = i_funct3[2] && (i_op_b == '0);
    div_ovf     = ((i_funct3 == MD_DIV) || (i_funct3 == MD_REM)) &&
                  (i_op_a == INT_MIN) && (i_op_b == '1);
    special     = div_zero || div_ovf;
    special_res = '0;
    if (div_zero)     special_res = i_funct3[1] ? i_op_a : '1;
    else if (div_ovf) special_res = i_funct3[1] ? '0 : INT_MIN;
  end

  assign accept  = (state == IDLE) && i_start && !i_flush;
  assign o_stall = !i_reset && (accept || (state == CALC) || (state == FIX));
  // MULH* take the high product half, REM* take the remainder
  assign sel_hi  = f3_q[2] ? f3_q[1] : (f3_q[1:0] != 2'b00);

  md_iter_datapath #(.XLEN(XLEN)) u_dp (
    .clk    (i_clk),
    .rst    (i_reset),
    .load   (accept && !special),
    .step   (state == CALC),
    .fix    (state == FIX),
    .is_div (f3_q[2]),
    .sel_hi (sel_hi),
    .neg_q  (neg_q_r),
    .neg_r  (neg_r_r),
    .op_a   (mag_a),
    .op_b   (mag_b),
    .result (dp_result)
  );

  // Sequencer FSM with registered busy/done/result
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= IDLE;
      cnt      <= '0;
      f3_q     <= '0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_result <= '0;
    end else begin
      o_done <= 1'b0;
      if (i_flush) begin
        // killed op: no done pulse, previous result stays visible
        state  <= IDLE;
        cnt    <= '0;
        o_busy <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (i_start) begin
              f3_q    <= i_funct3;
              neg_q_r <= sign_a ^ sign_b;
              neg_r_r <= sign_a;
              o_busy  <= 1'b1;
              cnt     <= '0;
              if (special) begin
                o_result <= special_res;
                o_done   <= 1'b1;
                state    <= DONE;
              end else begin
                state <= CALC;
              end
            end
          end
          CALC: begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(XLEN-1)) state <= FIX;
          end
          FIX: begin
            o_result <= dp_result;
            o_done   <= 1'b1;
            state    <= DONE;
          end
          DONE: begin
            // pipeline advances this cycle; the next op is taken from IDLE
            o_busy <= 1'b0;
            state  <= IDLE;
          end
          default: begin
            o_busy <= 1'b0;
            state  <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Scoreboard bench for ex_muldiv_sequencer: random and directed M-ops against a 64-bit arithmetic model.
module tb_ex_muldiv_sequencer;
  import ex_muldiv_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  f3;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  ex_muldiv_sequencer dut (
    .i_clk    (clk),
    .i_reset  (rst),
    .i_start  (start),
    .i_funct3 (f3),
    .i_op_a   (a),
    .i_op_b   (b),
    .i_flush  (flush),
    .o_stall  (stall),
    .o_busy   (busy),
    .o_done   (done),
    .o_result (result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference results straight from the RV32M definitions using wide arithmetic
  function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, p;
    longint unsigned ux, uy, up;
    int              ix, iy;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'h0, x};
    uy = {32'h0, y};
    ix = x;
    iy = y;
    case (f)
      MD_MUL:    begin up = ux * uy; return up[31:0]; end
      MD_MULH:   begin p = sx * sy; return p[63:32]; end
      MD_MULHSU: begin p = sx * longint'(uy); return p[63:32]; end
      MD_MULHU:  begin up = ux * uy; return up[63:32]; end
      MD_DIV: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ix / iy;
      end
      MD_DIVU: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      MD_REM: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        return ix % iy;
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    if (f[2] && y == 0) return 1'b1;
    return (f == MD_DIV || f == MD_REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = q.pop_front();
        chk("result", result, mon_e.res);
        chk("latency", 32'(cyc), 32'(mon_e.due));
      end
    end
  end

  // Issue one op, hold start while stalled, check stall length; returns in the DONE cycle
  task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                       input bit drop, output int t_acc);
    int   guard;
    int   n;
    bit   sp;
    exp_t e;
    start = 1'b1;
    f3    = f;
    a     = x;
    b     = y;
    #1;
    guard = 0;
    while (!stall && guard < 10) begin
      @(negedge clk); #1;
      guard++;
    end
    t_acc = cyc;
    if (!stall) begin
      chk("accept_timeout", 32'd0, 32'd1);
      start = 1'b0;
      return;
    end
    sp    = is_special(f, x, y);
    e.res = ref_md(f, x, y);
    e.due = t_acc + (sp ? 1 : 34);
    q.push_back(e);
    @(posedge clk);
    @(negedge clk); #1;
    n = 0;
    while (stall && n < 100) begin
      n++;
      @(negedge clk); #1;
    end
    chk("stall_cycles", 32'(n), sp ? 32'd0 : 32'd33);
    if (drop) start = 1'b0;
  endtask

  int t1, t2;
  logic [31:0] held;

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    flush = 1'b0;
    f3    = MD_MUL;
    a     = 32'd1;
    b     = 32'd1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk); #1;

    // Directed cases
    issue(MD_MUL, 32'd7, 32'd6, 1, t1);
    chk("mul_7x6", result, 32'd42);
    issue(MD_MULH, 32'h8000_0000, 32'h8000_0000, 1, t1);
    chk("mulh_min", result, 32'h4000_0000);
    issue(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, t1);
    chk("mulhu_max", result, 32'hFFFF_FFFE);
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1, t1);
    chk("div_m7_2", result, 32'hFFFF_FFFD);
    issue(MD_REM, 32'hFFFF_FFF9, 32'd2, 1, t1);
    chk("rem_m7_2", result, 32'hFFFF_FFFF);
    issue(MD_DIVU, 32'd5, 32'd0, 1, t1);
    chk("divu_by0", result, 32'hFFFF_FFFF);
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, t1);
    chk("div_ovf", result, 32'h8000_0000);

    // Flush at iteration 10 of a DIV
    @(negedge clk); #1;
    held  = result;
    start = 1'b1;
    f3    = MD_DIV;
    a     = 32'd1000;
    b     = 32'd7;
    @(posedge clk);
    repeat (11) @(negedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk); #1;
    flush = 1'b0;
    start = 1'b0;
    #1;
    chk("flush_stall", {31'd0, stall}, 32'd0);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_result", result, held);
    repeat (40) @(negedge clk);
    #1;
    issue(MD_MUL, 32'd3, 32'd3, 1, t1);
    chk("mul_after_flush", result, 32'd9);

    // Flush wins over a simultaneous start in IDLE
    @(negedge clk); #1;
    start = 1'b1;
    flush = 1'b1;
    #1;
    chk("flush_wins_stall", {31'd0, stall}, 32'd0);
    @(negedge clk); #1;
    chk("flush_wins_busy", {31'd0, busy}, 32'd0);
    start = 1'b0;
    flush = 1'b0;

    // Asynchronous reset mid-CALC
    @(negedge clk); #1;
    start = 1'b1;
    f3    = MD_MULHU;
    a     = 32'h1234_5678;
    b     = 32'h9ABC_DEF0;
    @(posedge clk);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_stall", {31'd0, stall}, 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;

    // Back-to-back MULs through DONE -> IDLE
    issue(MD_MUL, 32'd11, 32'd13, 0, t1);
    issue(MD_MUL, 32'hFFFF_FFFF, 32'd2, 1, t2);
    chk("b2b_spacing", 32'(t2 - t1), 32'd35);

    // Randomized ops with biased operand corners
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      logic [2:0]  rf;
      rf = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: ra = $urandom;
        1: ra = 32'h8000_0000;
        2: ra = 32'hFFFF_FFFF;
        default: ra = 32'($urandom_range(0, 15));
      endcase
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = 32'd0;
        2: rb = 32'hFFFF_FFFF;
        default: rb = 32'($urandom_range(0, 15));
      endcase
      issue(rf, ra, rb, $urandom_range(0, 1) == 1, t1);
    end
    start = 1'b0;

    repeat (5) @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", n_checks);
    $fatal(1);
  end

endmodule
